// File: rtl/turn_sequencer_if.sv
// Board/player signal bundle of the turn sequencer. The master side is the
// sequencer itself. The slave side is the board model, the switches and the AI.
interface turn_sequencer_if;
  logic [8:0] x_board;
  logic [8:0] o_board;
  logic       human_is_x;
  logic [8:0] human_cell;
  logic       human_go;
  logic [8:0] ai_cell;
  logic       ai_req;
  logic       ai_start;
  logic       ai_ack;
  logic       ai_nak;
  logic       ai_timeout;
  logic [8:0] cell_out;
  logic       write_en;
  logic       game_reset;
  logic       illegal;
  logic       x_to_move;
  logic [3:0] draw_count;
  logic       err;

  modport master (
    input  x_board, o_board, human_is_x, human_cell, human_go, ai_cell, ai_req,
    output ai_start, ai_ack, ai_nak, ai_timeout, cell_out, write_en,
           game_reset, illegal, x_to_move, draw_count, err
  );

  modport slave (
    output x_board, o_board, human_is_x, human_cell, human_go, ai_cell, ai_req,
    input  ai_start, ai_ack, ai_nak, ai_timeout, cell_out, write_en,
           game_reset, illegal, x_to_move, draw_count, err
  );
endinterface

// File: rtl/turn_sequencer.sv
// Turn sequencer: arbitrates the single board write port between the human
// player and the AI player. It checks move legality, issues one write pulse per
// move, waits for the board to reflect the move, and handles draws.
module turn_sequencer #(
  parameter int unsigned AI_TIMEOUT = 50000000,
  parameter int unsigned SETTLE_MAX = 4
) (
  input logic            clk,
  input logic            reset,
  turn_sequencer_if.master bus
);

  localparam int unsigned ACW  = $clog2(AI_TIMEOUT + 1);
  localparam int unsigned SCW  = (SETTLE_MAX > 1) ? $clog2(SETTLE_MAX) : 1;
  localparam logic [8:0]  FULL = 9'h1FF;

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT_MOVE,
    S_WRITE,
    S_SETTLE,
    S_DRAW_CLR
  } state_t;

  state_t           state, state_n;
  logic [8:0]       cell_q, cell_n;
  logic             xtm_q, xtm_n;
  logic             hx_q, hx_n;
  logic             go_q;
  logic             started_q, started_n;
  logic [ACW-1:0]   acnt_q, acnt_n;
  logic [SCW-1:0]   scnt_q, scnt_n;
  logic             err_q, err_n;
  logic [3:0]       draws_q, draws_n;

  logic             start_c, ack_c, nak_c, tmo_c, ill_c, we_c, gr_c;
  logic [8:0]       occ;
  logic             human_turn, go_edge, human_ok, ai_ok;

  assign occ        = bus.x_board | bus.o_board;
  assign human_turn = (xtm_q == hx_q);
  assign go_edge    = bus.human_go & ~go_q;
  assign human_ok   = $onehot(bus.human_cell) && ((bus.human_cell & occ) == '0);
  assign ai_ok      = $onehot(bus.ai_cell) && ((bus.ai_cell & occ) == '0);

  // Button history runs through reset so a button held across reset cannot
  // fake a rising edge.
  always_ff @(posedge clk) begin
    go_q <= bus.human_go;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      cell_q    <= '0;
      xtm_q     <= 1'b1;
      hx_q      <= 1'b0;
      started_q <= 1'b0;
      acnt_q    <= '0;
      scnt_q    <= '0;
      err_q     <= 1'b0;
      draws_q   <= '0;
    end else begin
      state     <= state_n;
      cell_q    <= cell_n;
      xtm_q     <= xtm_n;
      hx_q      <= hx_n;
      started_q <= started_n;
      acnt_q    <= acnt_n;
      scnt_q    <= scnt_n;
      err_q     <= err_n;
      draws_q   <= draws_n;
    end
  end

  // Next-state, register updates and pulse outputs.
  always_comb begin
    state_n   = state;
    cell_n    = cell_q;
    xtm_n     = xtm_q;
    hx_n      = hx_q;
    started_n = started_q;
    acnt_n    = acnt_q;
    scnt_n    = scnt_q;
    err_n     = err_q;
    draws_n   = draws_q;
    start_c   = 1'b0;
    ack_c     = 1'b0;
    nak_c     = 1'b0;
    tmo_c     = 1'b0;
    ill_c     = 1'b0;
    we_c      = 1'b0;
    gr_c      = 1'b0;

    case (state)
      S_INIT: begin
        gr_c    = 1'b1;
        hx_n    = bus.human_is_x;
        xtm_n   = 1'b1;
        state_n = S_WAIT_MOVE;
      end

      S_WAIT_MOVE: begin
        if (human_turn) begin
          if (go_edge) begin
            if (human_ok) begin
              cell_n  = bus.human_cell;
              state_n = S_WRITE;
            end else begin
              ill_c = 1'b1;
            end
          end
        end else begin
          if (!started_q) begin
            start_c   = 1'b1;
            started_n = 1'b1;
            acnt_n    = ACW'(1);
          end else if (acnt_q != ACW'(AI_TIMEOUT)) begin
            acnt_n = acnt_q + 1'b1;
          end
          // A request in the timeout cycle takes precedence over the timeout.
          if (bus.ai_req) begin
            if (ai_ok) begin
              ack_c   = 1'b1;
              cell_n  = bus.ai_cell;
              state_n = S_WRITE;
            end else begin
              nak_c = 1'b1;
            end
          end else if (started_q && (acnt_q == ACW'(AI_TIMEOUT))) begin
            tmo_c     = 1'b1;
            started_n = 1'b0;
          end
        end
      end

      S_WRITE: begin
        we_c    = 1'b1;
        scnt_n  = '0;
        state_n = S_SETTLE;
      end

      S_SETTLE: begin
        if ((bus.x_board == '0) && (bus.o_board == '0)) begin
          xtm_n   = 1'b1;
          state_n = S_WAIT_MOVE;
        end else if ((cell_q & occ) != '0) begin
          xtm_n   = ~xtm_q;
          state_n = (occ == FULL) ? S_DRAW_CLR : S_WAIT_MOVE;
        end else if (scnt_q == SCW'(SETTLE_MAX - 1)) begin
          err_n   = 1'b1;
          state_n = S_INIT;
        end else begin
          scnt_n = scnt_q + 1'b1;
        end
      end

      S_DRAW_CLR: begin
        gr_c    = 1'b1;
        xtm_n   = 1'b1;
        if (draws_q != 4'hF) draws_n = draws_q + 4'd1;
        state_n = S_WAIT_MOVE;
      end

      default: state_n = S_INIT;
    endcase

    if ((state_n != S_WRITE) && (state_n != S_SETTLE)) cell_n = '0;
    if (state_n != S_WAIT_MOVE) started_n = 1'b0;
  end

  // Strobes are decoded from state, so they are masked by reset to drop in the
  // very cycle reset is sampled.
  assign bus.ai_start   = start_c & ~reset;
  assign bus.ai_ack     = ack_c & ~reset;
  assign bus.ai_nak     = nak_c & ~reset;
  assign bus.ai_timeout = tmo_c & ~reset;
  assign bus.illegal    = ill_c & ~reset;
  assign bus.write_en   = we_c & ~reset;
  assign bus.game_reset = gr_c & ~reset;
  assign bus.cell_out   = cell_q;
  assign bus.x_to_move  = xtm_q;
  assign bus.draw_count = draws_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Testbench for turn_sequencer. It provides a board model and a scoreboard of
// expected writes. Inputs are driven 1 ns after posedge, and outputs are
// sampled at negedge.
module tb_turn_sequencer;

  logic clk;
  logic reset;
  turn_sequencer_if bus();

  turn_sequencer #(.AI_TIMEOUT(8), .SETTLE_MAX(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         n_checks;
  int         n_fail;
  logic [8:0] sb[$];
  logic       tb_xtm;
  logic       tb_hx;
  logic       observed;
  logic       prev_we;
  logic       board_hold;
  logic [8:0] x_b;
  logic [8:0] o_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board model: clears on game_reset, otherwise records the mover's mark.
  always @(posedge clk) begin
    if (reset || bus.game_reset) begin
      x_b <= '0;
      o_b <= '0;
    end else if (bus.write_en && !board_hold) begin
      if (bus.x_to_move) x_b <= x_b | bus.cell_out;
      else               o_b <= o_b | bus.cell_out;
    end
  end
  assign bus.x_board = x_b;
  assign bus.o_board = o_b;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Negedge sample. Every write pulse is matched against the scoreboard.
  task automatic observe;
    logic [8:0] exp;
    @(negedge clk);
    observed = 1'b1;
    if (bus.write_en === 1'b1) begin
      n_checks++;
      if (prev_we) begin
        n_fail++;
        $display("FAIL write_gap: write_en=1 on two consecutive cycles, required a low cycle");
      end
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: cell_out=%h with no move expected", bus.cell_out);
      end else begin
        exp = sb.pop_front();
        if (bus.cell_out !== exp) begin
          n_fail++;
          $display("FAIL write_cell: cell_out=%h required %h", bus.cell_out, exp);
        end
      end
    end
    prev_we = (bus.write_en === 1'b1);
  endtask

  task automatic advance;
    if (!observed) observe();
    @(posedge clk);
    #1;
    observed = 1'b0;
  endtask

  // Plays one legal move for whoever is to move. The task ends at the negedge
  // of the cycle after SETTLE.
  task automatic play_move(input logic [8:0] c);
    logic hit;
    hit = 1'b0;
    sb.push_back(c);
    if (tb_xtm == tb_hx) begin
      bus.human_cell = c;
      bus.human_go   = 1'b1;
    end else begin
      bus.ai_cell = c;
      bus.ai_req  = 1'b1;
    end
    for (int i = 0; i < 20 && !hit; i++) begin
      observe();
      if (bus.write_en === 1'b1) hit = 1'b1;
      advance();
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL move_timeout: no write_en for cell %h within 20 cycles", c);
    end
    bus.human_go = 1'b0;
    bus.ai_req   = 1'b0;
    observe();
    advance();
    observe();
    n_checks++;
    if (bus.x_to_move !== ~tb_xtm) begin
      n_fail++;
      $display("FAIL move_toggle: x_to_move=%b required %b", bus.x_to_move, ~tb_xtm);
    end
    tb_xtm = ~tb_xtm;
  endtask

  task automatic test_reset;
    reset          = 1'b1;
    bus.human_is_x = 1'b1;
    bus.human_cell = '0;
    bus.human_go   = 1'b0;
    bus.ai_cell    = '0;
    bus.ai_req     = 1'b0;
    advance();
    advance();
    observe();
    n_checks++;
    if ({bus.write_en, bus.game_reset, bus.ai_start, bus.ai_ack, bus.ai_nak,
         bus.ai_timeout, bus.illegal, bus.err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 00000000",
               {bus.write_en, bus.game_reset, bus.ai_start, bus.ai_ack, bus.ai_nak,
                bus.ai_timeout, bus.illegal, bus.err});
    end
    n_checks++;
    if ({bus.x_to_move, bus.draw_count, bus.cell_out} !== {1'b1, 4'h0, 9'h000}) begin
      n_fail++;
      $display("FAIL reset_regs: x_to_move=%b draw_count=%0d cell_out=%h required 1/0/000",
               bus.x_to_move, bus.draw_count, bus.cell_out);
    end
    advance();
    reset = 1'b0;
    observe();
    n_checks++;
    if (bus.game_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL init_game_reset: game_reset=%b required 1", bus.game_reset);
    end
    advance();
    observe();
    n_checks++;
    if ({bus.game_reset, bus.x_to_move, bus.ai_start, bus.write_en} !== 4'b0100) begin
      n_fail++;
      $display("FAIL post_init: game_reset/x_to_move/ai_start/write_en=%b required 0100",
               {bus.game_reset, bus.x_to_move, bus.ai_start, bus.write_en});
    end
    advance();
    tb_hx  = 1'b1;
    tb_xtm = 1'b1;
  endtask

  // Cycle j=0 is the button edge. The write is expected at j=1 and ai_start at
  // j=3.
  task automatic test_human_hold;
    bus.human_cell = 9'h001;
    bus.human_go   = 1'b1;
    sb.push_back(9'h001);
    for (int j = 0; j < 10; j++) begin
      observe();
      n_checks++;
      if (bus.write_en !== 1'(j == 1)) begin
        n_fail++;
        $display("FAIL hold_write: cycle %0d write_en=%b required %b", j, bus.write_en, (j == 1));
      end
      n_checks++;
      if (bus.ai_start !== 1'(j == 3)) begin
        n_fail++;
        $display("FAIL hold_ai_start: cycle %0d ai_start=%b required %b", j, bus.ai_start, (j == 3));
      end
      n_checks++;
      if (bus.illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_illegal: cycle %0d illegal=%b required 0", j, bus.illegal);
      end
      if (j == 9) begin
        n_checks++;
        if (bus.x_to_move !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_turn: x_to_move=%b required 0", bus.x_to_move);
        end
      end
      advance();
    end
    bus.human_go = 1'b0;
  endtask

  // ai_start was at cycle 3. The timeout is expected at 11 and the reissue at 12.
  task automatic test_ai_timeout;
    for (int k = 10; k < 14; k++) begin
      observe();
      n_checks++;
      if (bus.ai_timeout !== 1'(k == 11)) begin
        n_fail++;
        $display("FAIL ai_timeout: cycle %0d ai_timeout=%b required %b", k, bus.ai_timeout, (k == 11));
      end
      n_checks++;
      if (bus.ai_start !== 1'(k == 12)) begin
        n_fail++;
        $display("FAIL ai_restart: cycle %0d ai_start=%b required %b", k, bus.ai_start, (k == 12));
      end
      advance();
    end
  endtask

  task automatic test_ai_nak_ack;
    bus.ai_req  = 1'b1;
    bus.ai_cell = 9'h001;
    observe();
    n_checks++;
    if ({bus.ai_nak, bus.ai_ack, bus.write_en, bus.ai_start} !== 4'b1000) begin
      n_fail++;
      $display("FAIL ai_nak: nak/ack/write_en/ai_start=%b required 1000",
               {bus.ai_nak, bus.ai_ack, bus.write_en, bus.ai_start});
    end
    advance();
    bus.ai_cell = 9'h010;
    sb.push_back(9'h010);
    observe();
    n_checks++;
    if ({bus.ai_nak, bus.ai_ack, bus.ai_start} !== 3'b010) begin
      n_fail++;
      $display("FAIL ai_ack: nak/ack/ai_start=%b required 010",
               {bus.ai_nak, bus.ai_ack, bus.ai_start});
    end
    advance();
    bus.ai_req = 1'b0;
    observe();
    n_checks++;
    if (bus.write_en !== 1'b1) begin
      n_fail++;
      $display("FAIL ai_write: write_en=%b required 1", bus.write_en);
    end
    advance();
    observe();
    advance();
    observe();
    n_checks++;
    if ({bus.x_to_move, bus.ai_start} !== 2'b10) begin
      n_fail++;
      $display("FAIL ai_turn_end: x_to_move/ai_start=%b required 10", {bus.x_to_move, bus.ai_start});
    end
    advance();
    tb_xtm = 1'b1;
  endtask

  task automatic test_illegal_human;
    logic [8:0] bad [4];
    bad = '{9'h001, 9'h010, 9'h0C0, 9'h000};
    for (int i = 0; i < 4; i++) begin
      bus.human_cell = bad[i];
      bus.human_go   = 1'b1;
      observe();
      n_checks++;
      if ({bus.illegal, bus.write_en} !== 2'b10) begin
        n_fail++;
        $display("FAIL illegal_pulse: cell %h illegal/write_en=%b required 10",
                 bad[i], {bus.illegal, bus.write_en});
      end
      advance();
      bus.human_go = 1'b0;
      observe();
      n_checks++;
      if (bus.illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_width: cell %h illegal=%b required 0", bad[i], bus.illegal);
      end
      advance();
    end
  endtask

  task automatic test_ignored_inputs;
    bus.ai_cell = 9'h100;
    bus.ai_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      observe();
      n_checks++;
      if ({bus.ai_ack, bus.ai_nak, bus.write_en} !== 3'b000) begin
        n_fail++;
        $display("FAIL ai_on_human_turn: ack/nak/write_en=%b required 000",
                 {bus.ai_ack, bus.ai_nak, bus.write_en});
      end
      advance();
    end
    bus.ai_req = 1'b0;
    play_move(9'h100);
    n_checks++;
    if (bus.ai_start !== 1'b1) begin
      n_fail++;
      $display("FAIL ai_start_after_human: ai_start=%b required 1", bus.ai_start);
    end
    advance();
    bus.human_cell = 9'h004;
    bus.human_go   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      observe();
      n_checks++;
      if ({bus.illegal, bus.write_en} !== 2'b00) begin
        n_fail++;
        $display("FAIL human_on_ai_turn: illegal/write_en=%b required 00",
                 {bus.illegal, bus.write_en});
      end
      advance();
    end
    bus.human_go = 1'b0;
    advance();
  endtask

  task automatic test_draw;
    logic [8:0] seq [9];
    seq = '{9'h001, 9'h010, 9'h100, 9'h004, 9'h040, 9'h008, 9'h020, 9'h080, 9'h002};
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
    observe();
    advance();
    tb_xtm = 1'b1;
    for (int i = 0; i < 9; i++) begin
      play_move(seq[i]);
      if (i < 8) advance();
    end
    n_checks++;
    if ({bus.game_reset, bus.draw_count} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL draw_clear: game_reset=%b draw_count=%0d required 1/0",
               bus.game_reset, bus.draw_count);
    end
    advance();
    observe();
    n_checks++;
    if ({bus.game_reset, bus.draw_count, bus.x_to_move} !== {1'b0, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL draw_after: game_reset=%b draw_count=%0d x_to_move=%b required 0/1/1",
               bus.game_reset, bus.draw_count, bus.x_to_move);
    end
    advance();
    tb_xtm = 1'b1;
  endtask

  // The board ignores the write. SETTLE lasts 4 cycles, then err is set and
  // INIT pulses game_reset.
  task automatic test_settle_err;
    logic hit;
    play_move(9'h001);
    advance();
    board_hold  = 1'b1;
    bus.ai_cell = 9'h010;
    bus.ai_req  = 1'b1;
    sb.push_back(9'h010);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      observe();
      if (bus.write_en === 1'b1) hit = 1'b1;
      advance();
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL err_move_timeout: no write_en within 20 cycles");
    end
    bus.ai_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      observe();
      n_checks++;
      if ({bus.err, bus.game_reset} !== 2'b00) begin
        n_fail++;
        $display("FAIL settle_early: settle cycle %0d err/game_reset=%b required 00",
                 k, {bus.err, bus.game_reset});
      end
      advance();
    end
    observe();
    n_checks++;
    if ({bus.err, bus.game_reset} !== 2'b11) begin
      n_fail++;
      $display("FAIL settle_err: err/game_reset=%b required 11", {bus.err, bus.game_reset});
    end
    advance();
    observe();
    n_checks++;
    if ({bus.err, bus.game_reset, bus.x_to_move} !== 3'b101) begin
      n_fail++;
      $display("FAIL err_sticky: err/game_reset/x_to_move=%b required 101",
               {bus.err, bus.game_reset, bus.x_to_move});
    end
    board_hold = 1'b0;
    advance();
    tb_xtm = 1'b1;
  endtask

  task automatic test_reset_in_write;
    bus.human_cell = 9'h001;
    bus.human_go   = 1'b1;
    observe();
    n_checks++;
    if (bus.write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_edge: write_en=%b required 0", bus.write_en);
    end
    advance();
    reset = 1'b1;
    observe();
    n_checks++;
    if ({bus.write_en, bus.game_reset} !== 2'b00) begin
      n_fail++;
      $display("FAIL rw_drop: write_en/game_reset=%b required 00", {bus.write_en, bus.game_reset});
    end
    advance();
    bus.human_go = 1'b0;
    observe();
    n_checks++;
    if ({bus.cell_out, bus.err, bus.x_to_move, bus.write_en} !== {9'h000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rw_cleared: cell_out=%h err=%b x_to_move=%b write_en=%b required 000/0/1/0",
               bus.cell_out, bus.err, bus.x_to_move, bus.write_en);
    end
    advance();
    reset = 1'b0;
    observe();
    n_checks++;
    if (bus.game_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_init: game_reset=%b required 1", bus.game_reset);
    end
    advance();
    observe();
    n_checks++;
    if (bus.game_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_init_width: game_reset=%b required 0", bus.game_reset);
    end
    advance();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    observed   = 1'b0;
    prev_we    = 1'b0;
    board_hold = 1'b0;
    tb_hx      = 1'b1;
    tb_xtm     = 1'b1;
    test_reset();
    test_human_hold();
    test_ai_timeout();
    test_ai_nak_ack();
    test_illegal_human();
    test_ignored_inputs();
    test_draw();
    test_settle_err();
    test_reset_in_write();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected writes never seen, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
Sequences play on the 9-cell board datapath. Arbitrates the single move write port (one-hot cell + write strobe) between a human player (switches + debounced button) and an AI player (req/ack handshake). Checks legality against the current X/O boards, issues exactly one write pulse per move and waits for the board to update. Also detects draws and clears the board, and tracks whose turn it is so the correct requester is served.

Parameters:
AI_TIMEOUT, 50000000, cycles allowed from ai_start until ai_req before a timeout is flagged and ai_start is reissued
SETTLE_MAX, 4, cycles allowed after write_en for the board to reflect the move before err is raised

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
x_board  in  9  X occupancy from board model
o_board  in  9  O occupancy from board model
human_is_x  in  1  1: human plays X, AI plays O; sampled only in INIT
human_cell  in  9  one-hot cell select from switches
human_go  in  1  debounced move button, level
ai_cell  in  9  one-hot AI move, valid while ai_req=1
ai_req  in  1  AI move request
ai_start  out  1  1-cycle pulse: AI should compute a move
ai_ack  out  1  1-cycle pulse: AI move accepted
ai_nak  out  1  1-cycle pulse: AI move rejected (illegal)
ai_timeout  out  1  1-cycle pulse on AI timeout
cell_out  out  9  one-hot cell to board model, valid with write_en
write_en  out  1  board write strobe
game_reset  out  1  board clear strobe
illegal  out  1  1-cycle pulse: human move rejected
x_to_move  out  1  1 when X is to move
draw_count  out  4  draws since reset, saturates at 15
err  out  1  sticky: board failed to update within SETTLE_MAX

Behaviour:
- Reset (sync) puts every output at 0 except x_to_move=1. State goes to INIT. write_en and game_reset drop in the same cycle that reset is sampled, even mid-write. err and draw_count clear.
- States: INIT, WAIT_MOVE, WRITE, SETTLE, DRAW_CLR.
- INIT: assert game_reset for exactly 1 cycle, latch human_is_x, set x_to_move=1, then go to WAIT_MOVE.
- Mover is human when x_to_move==human_is_x, else AI.
- WAIT_MOVE, human mover:
  - Human move accepted only on a rising edge of human_go (previous-cycle register). A held button never produces a second move.
  - human_cell is sampled in the edge cycle.
- WAIT_MOVE, AI mover:
  - ai_start pulses on the first WAIT_MOVE cycle of each AI turn. A timeout counter starts then.
  - Counter reaching AI_TIMEOUT with no ai_req: ai_timeout pulses, ai_start pulses again the next cycle, counter restarts.
  - ai_req is ignored on human turns, with no ack or nak.
- Legality: candidate is legal iff it has exactly one bit set and (candidate & (x_board|o_board))==0.
  - Illegal human move: illegal pulses 1 cycle; stay in WAIT_MOVE.
  - Illegal AI move: ai_nak pulses; stay in WAIT_MOVE; ai_start is not reissued.
  - Legal move: register it into cell_out and go to WRITE. ai_ack pulses in the same cycle for AI moves.
- WRITE: write_en=1 for exactly 1 cycle, then 0. write_en is never high on two consecutive cycles; the board model needs a low cycle to re-arm. cell_out holds until SETTLE exits. Go to SETTLE.
- SETTLE: evaluated each cycle, priority order:
  1. Both boards==0: the board model detected a win and self-cleared. Set x_to_move=1, go to WAIT_MOVE.
  2. cell_out bit is present in (x_board|o_board): toggle x_to_move. If (x_board|o_board)==9'h1FF go to DRAW_CLR, else WAIT_MOVE.
  3. SETTLE_MAX cycles elapse: set err, go to INIT.
- DRAW_CLR: game_reset=1 for 1 cycle, draw_count+1 (saturating), x_to_move=1, go to WAIT_MOVE.
- cell_out returns to 0 whenever the state is not WRITE or SETTLE.
- Simultaneous events:
  - reset wins over everything.
  - human_go edge during an AI turn is discarded and not queued.
  - ai_req and timeout in the same cycle: ai_req wins, no ai_timeout pulse.
- Move latency: human_go edge to write_en high is 2 cycles (edge cycle, then WRITE).

Test Plan:
- Reset then INIT -> game_reset high exactly 1 cycle; x_to_move=1; all other outputs 0.
- human_is_x=1, human_cell=9'h001, human_go rises and is held 10 cycles -> exactly one write_en pulse with cell_out=9'h001; after board x_board=9'h001, x_to_move=0 and ai_start pulses.
- AI turn, ai_req with ai_cell=9'h001 while x_board=9'h001 -> ai_nak pulse, no write_en. Then ai_cell=9'h010 -> ai_ack, write_en, cell_out=9'h010.
- AI turn with ai_req never asserted, AI_TIMEOUT=8 -> ai_timeout at cycle 8 after ai_start; ai_start pulses again 1 cycle later.
- Fill the board with no win, last move brings x|o to 9'h1FF -> DRAW_CLR: game_reset 1 cycle, draw_count 0->1, x_to_move=1.
- Board model holds boards unchanged after write_en, SETTLE_MAX=4 -> err=1 after 4 cycles, then INIT with game_reset pulse. Separately, reset asserted during WRITE -> write_en=0 the same cycle.
